// File: rtl/osc_trig_capture_if.sv
// Sample streams around the oscilloscope trigger/capture block.
// The input side faces the prefetch FIFO read port and the output side faces the frame consumer.
interface osc_trig_capture_if #(
  parameter int c_DATA_WIDTH = 8
);
  // Handshake rule for both streams: a beat moves on a rising clock edge
  // exactly when vld & rdy are both 1. The producer holds data/last stable
  // while vld=1 and rdy=0. rdy may depend combinationally on vld.
  logic [c_DATA_WIDTH-1:0] in_data;
  logic                    in_vld;
  logic                    in_rdy;
  logic [c_DATA_WIDTH-1:0] out_data;
  logic                    out_vld;
  logic                    out_rdy;
  logic                    out_last;

  modport master (
    output in_data, in_vld, out_rdy,
    input  in_rdy, out_data, out_vld, out_last
  );

  modport slave (
    input  in_data, in_vld, out_rdy,
    output in_rdy, out_data, out_vld, out_last
  );
endinterface

// File: rtl/osc_trig_capture.sv
// Edge/level trigger and fixed-length frame capture on a sample stream.
// It waits in ARMED for a threshold crossing or a forced trigger, then streams frame_len beats.
module osc_trig_capture #(
  parameter int c_DATA_WIDTH = 8,
  parameter int c_LEN_WIDTH  = 12
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  osc_trig_capture_if.slave       s_if,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [c_DATA_WIDTH-1:0] trig_level,
  input  logic                    trig_edge,
  input  logic                    trig_force,
  input  logic [c_LEN_WIDTH-1:0]  frame_len,
  output logic                    busy,
  output logic                    triggered,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [c_LEN_WIDTH-1:0] c_ONE = 1;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_DATA_WIDTH-1:0] r_level;
  logic                    r_edge;
  logic [c_LEN_WIDTH-1:0]  r_len;
  logic [c_LEN_WIDTH-1:0]  r_loaded;
  logic [c_DATA_WIDTH-1:0] r_prev;
  logic                    r_prev_vld;
  logic [c_DATA_WIDTH-1:0] r_out_data;
  logic                    r_out_vld;
  logic                    r_out_last;
  logic                    r_triggered;

  logic                    w_in_rdy;
  logic                    w_take;
  logic                    w_xfer;
  logic                    w_arm_ok;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_hit;
  logic [c_LEN_WIDTH-1:0]  w_loaded_inc;

  assign w_arm_ok     = arm & (frame_len != '0);
  assign w_take       = s_if.in_vld & w_in_rdy;
  assign w_xfer       = r_out_vld & s_if.out_rdy;
  assign w_rise       = (r_prev < r_level) & (s_if.in_data >= r_level);
  assign w_fall       = (r_prev > r_level) & (s_if.in_data <= r_level);
  // Level crossings need a previous sample; force triggers on any sample.
  assign w_hit        = trig_force | (r_prev_vld & (r_edge ? w_fall : w_rise));
  assign w_loaded_inc = r_loaded + c_ONE;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arm_ok) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        w_in_rdy = 1'b1;
        if (s_if.in_vld & w_hit) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_in_rdy = (r_loaded < r_len) & (~r_out_vld | s_if.out_rdy);
        if (w_xfer & r_out_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort also blocks the pop in its own cycle so no sample is lost in flight.
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_in_rdy    = 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_level     <= '0;
      r_edge      <= 1'b0;
      r_len       <= '0;
      r_loaded    <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_out_data  <= '0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_triggered <= 1'b0;
    end else if (abort) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arm_ok) begin
            r_level     <= trig_level;
            r_edge      <= trig_edge;
            r_len       <= frame_len;
            r_triggered <= 1'b0;
            r_prev_vld  <= 1'b0;
          end
        end
        S_ARMED: begin
          if (w_take) begin
            if (w_hit) begin
              r_out_data  <= s_if.in_data;
              r_out_vld   <= 1'b1;
              r_out_last  <= (r_len == c_ONE);
              r_loaded    <= c_ONE;
              r_triggered <= 1'b1;
            end else begin
              r_prev     <= s_if.in_data;
              r_prev_vld <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (w_take) begin
            r_out_data <= s_if.in_data;
            r_out_vld  <= 1'b1;
            r_out_last <= (w_loaded_inc == r_len);
            r_loaded   <= w_loaded_inc;
          end else if (w_xfer) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_if.in_rdy   = w_in_rdy;
  assign s_if.out_data = r_out_data;
  assign s_if.out_vld  = r_out_vld;
  assign s_if.out_last = r_out_last;
  assign busy          = (r_state != S_IDLE);
  assign triggered     = r_triggered;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/osc_trig_capture.md
OSC_TRIG_CAPTURE -- requirements
Module: osc_trig_capture

Interface
REQ-001 Parameter c_DATA_WIDTH, 8: sample width in bits, legal 1..16.
REQ-002 Parameter c_LEN_WIDTH, 12: frame length counter width in bits, legal 4..16.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: rd_clk  in  1  rising-edge clock, shared with the upstream prefetch FIFO read side.
REQ-004 rd_rst  in  1  synchronous active-high reset.
REQ-005 in_data  in  c_DATA_WIDTH  sample from the upstream FIFO (its rd_data).
REQ-006 in_vld  in  1  sample valid (the FIFO's rd_vld).
REQ-007 in_rdy  out  1  pop request, wired to the FIFO's rd_en. A sample is consumed only when in_vld & in_rdy.
REQ-008 arm  in  1  single-cycle pulse that starts a capture.
REQ-009 abort  in  1  single-cycle pulse that cancels any capture.
REQ-010 trig_level  in  c_DATA_WIDTH  unsigned threshold, sampled at arm.
REQ-011 trig_edge  in  1  edge select, 0 = rising, 1 = falling; sampled at arm.
REQ-012 trig_force  in  1  level input that forces a trigger while ARMED.
REQ-013 frame_len  in  c_LEN_WIDTH  number of samples to output, sampled at arm.
REQ-014 out_data  out  c_DATA_WIDTH  captured sample (register output).
REQ-015 out_vld  out  1  out_data valid.
REQ-016 out_rdy  in  1  downstream accept; a beat transfers on out_vld & out_rdy.
REQ-017 out_last  out  1  marks the final beat of a frame; valid only with out_vld.
REQ-018 busy  out  1  high in ARMED or CAPTURE.
REQ-019 triggered  out  1  sticky flag; set on trigger, cleared by the next accepted arm.

Function
REQ-020 The state machine SHALL have three states: IDLE, ARMED and CAPTURE.
REQ-021 In IDLE, in_rdy SHALL be 0 so the FIFO back-pressures and no samples are consumed.
REQ-022 In IDLE, an arm pulse with frame_len != 0 SHALL do the following:
- latch trig_level, trig_edge and frame_len;
- clear triggered and the prev-sample-valid flag;
- move to ARMED on the next cycle.
REQ-023 An arm pulse with frame_len == 0 SHALL be ignored, and the block SHALL stay in IDLE.
REQ-024 An arm pulse while busy=1 SHALL be ignored.
REQ-025 In ARMED, in_rdy SHALL be 1 and each consumed sample SHALL be compared against the previous consumed sample (prev). Non-trigger samples are discarded.
REQ-026 The rising trigger condition is prev < level AND cur >= level. The falling trigger condition is prev > level AND cur <= level. Both are unsigned compares.
REQ-027 The first sample consumed after arm has no prev and SHALL NOT trigger by level; it only loads prev.
REQ-028 A sample consumed while trig_force=1 in ARMED SHALL trigger unconditionally, including the first sample.
REQ-029 On trigger, the triggering sample SHALL be frame beat 0:
- it is loaded into out_data in the consuming cycle;
- out_vld is 1 from the next cycle;
- triggered is set;
- the loaded count is set to 1;
- the state moves to CAPTURE.
REQ-030 If frame_len == 1, beat 0 SHALL carry out_last=1.
REQ-031 In CAPTURE, in_rdy SHALL be (loaded < frame_len) & (~out_vld | out_rdy), so samples stream at one beat per cycle with no bubbles when out_rdy=1.
REQ-032 Each consumed sample in CAPTURE SHALL load out_data, set out_vld and increment loaded. out_last SHALL be 1 when loaded becomes frame_len.
REQ-033 With out_vld=1 and out_rdy=0, out_data, out_vld and out_last SHALL hold stable.
REQ-034 When the out_last beat transfers, the block SHALL go to IDLE on the next cycle with out_vld=0. No further samples are consumed.
REQ-035 abort SHALL take effect in any state:
- go to IDLE next cycle;
- out_vld=0 and out_last=0;
- in_rdy=0 from the next cycle;
- triggered keeps its value.
REQ-036 abort and arm in the same cycle: abort SHALL win.
REQ-037 Consumed beats SHALL be out_data values in upstream order, none dropped or duplicated. The total beats per frame SHALL equal the latched frame_len, exactly.
REQ-038 Counters SHALL be c_LEN_WIDTH bits wide. frame_len = 2^c_LEN_WIDTH-1 SHALL work without wrap.

Reset
REQ-039 While rd_rst=1 at a rising rd_clk edge, the block SHALL apply: state=IDLE, in_rdy=0, out_vld=0, out_last=0, out_data=0, busy=0, triggered=0, loaded=0, prev-valid=0.
REQ-040 Reset asserted mid-capture SHALL discard the frame. The block SHALL be armable from the first cycle after rd_rst deasserts.

Verification
REQ-041 Rising trigger: arm with level=0x80, edge=0, len=4; feed 0x10,0x7F,0x80,0x90,0xA0,0xB0,0xC0 with out_rdy=1 -> out beats 0x80,0x90,0xA0,0xB0, last on 0xB0; 0xC0 not consumed; triggered=1; IDLE.
REQ-042 Falling trigger plus first-sample rule: edge=1, level=0x40, len=2; feed 0x30,0x50,0x40,0x20 -> beats 0x40,0x20; 0x30 does not trigger.
REQ-043 Backpressure: len=8 after trigger; toggle out_rdy 1,0,0,1 repeating -> exactly 8 beats in order, out_data stable while stalled, in_rdy=0 whenever out_vld & ~out_rdy.
REQ-044 Force and len=1: arm len=1, trig_force=1, feed 0x55 -> single beat 0x55 with out_last=1, then busy=0.
REQ-045 Abort and illegal arm: abort on beat 3 of len=10 -> out_vld=0 next cycle, IDLE, in_rdy=0. arm with len=0 -> busy stays 0. arm+abort same cycle -> stays IDLE.
REQ-046 Reset mid-frame: assert rd_rst during CAPTURE -> all outputs at reset values next cycle; a re-arm afterwards captures a correct frame.
